gearbox_67b_64b: RTL and testbench
==================================

# gearbox_67b_64b

Transmit-side gearbox that sits directly downstream of the 64B/67B encoder. It packs the encoder's 67-bit blocks (inversion flag, 2-bit sync header, 64-bit payload) into a contiguous bit stream and emits it as 64-bit words for the SERDES transmit datapath. The encoder stalls through a ready/valid handshake, which lets it accept exactly 64 blocks for every 67 output words.

## Interface
Parameters:
- none. Widths are fixed at 67 bits in and 64 bits out.

Ports:
- USER_CLK  in  1  single clock; all logic is on its rising edge.
- SYSTEM_RESET_N  in  1  asynchronous, active-low reset.
- DATA_IN  in  67  block from the encoder. Bit 66 is the inversion flag, 65:64 the sync header, 63:0 the payload. Transmitted bit 66 first.
- DATA_IN_VALID  in  1  DATA_IN holds a block.
- DATA_IN_READY  out  1  gearbox accepts DATA_IN this cycle. Registered.
- DATA_OUT  out  64  output word. DATA_OUT[63] is transmitted first.
- DATA_OUT_VALID  out  1  DATA_OUT holds a valid word. Registered.

## Operation
- Buffer: 131-bit shift buffer, left-aligned (MSB first). FILL counter, 7 bits, range 0..66.
- Accept: occurs when DATA_IN_VALID && DATA_IN_READY.
  - The block is appended immediately after the FILL bits already held.
  - fill_sum = FILL + 67.
  - If no block is accepted, fill_sum = FILL.
- Emit: if fill_sum >= 64, the top 64 bits of the buffer go to DATA_OUT with DATA_OUT_VALID=1. The remainder shifts to the MSB end and FILL <= fill_sum − 64.
- If fill_sum < 64: DATA_OUT_VALID=0, DATA_OUT holds its previous value, FILL <= fill_sum.
- DATA_IN_READY <= (next FILL < 64). FILL 64..66 therefore always stalls the input for one cycle.
- Invariant: FILL never exceeds 66, and no bit is ever dropped or duplicated.
- Backpressure: while DATA_IN_READY=0 the upstream block is held and stays valid. The gearbox ignores DATA_IN in that cycle.
- Underrun: if input is absent and FILL < 64, no word is emitted and the residual bits are held indefinitely.
- Sync header and inversion bits pass through unmodified. The gearbox does not check them.

## Timing
- Reset values (asynchronous):
  - FILL=0, buffer=0.
  - DATA_OUT=64'h0, DATA_OUT_VALID=0.
  - DATA_IN_READY=0.
- First edge after reset release: DATA_IN_READY=1. No block is accepted on that edge.
- Latency: a block accepted at edge N puts its first bit on DATA_OUT after edge N (one register stage).
- Continuous DATA_IN_VALID from reset:
  - FILL goes 0,3,6,…,63,66 over 22 accepts.
  - Then READY=0 for one cycle and FILL=2.
  - Pattern period: 67 output cycles, 64 accepts, 3 stall cycles. DATA_OUT_VALID stays 1 every cycle after the first accept.
- Reset asserted mid-stream: the buffer contents and the partial word are discarded immediately. The restart behaves as a fresh reset.
- DATA_IN_VALID deasserted while READY=1: FILL is unchanged if < 64, else it decreases by 64.

## Structure
- Shared package:
  - INTERLAKEN_BLOCK_W=67, SERDES_W=64.
  - Field index constants: INV_BIT=66, SYNC_HI=65, SYNC_LO=64.
  - These are shared with the 64B/67B encoder and the receive-side block-lock logic.
- Single module, no sub-module. A 131-bit barrel insert plus shift is the only datapath.
- Optional: a debug counter output for stall cycles. It is not part of this spec.

## Test plan
- Single block {3'b010, 64'h0123456789ABCDEF}, valid one cycle, then idle:
  - DATA_OUT=64'h402468ACF13579BD, VALID=1, one cycle.
  - Then VALID=0 with FILL=3 holding 3'b111.
- Continuous valid with incrementing payloads and header 2'b01:
  - READY low exactly at the 23rd cycle after reset release, then every 22 or 23 cycles.
  - 64 accepts per 67 valid words.
  - The serialized bit stream equals the concatenation of the input blocks.
- Random DATA_IN_VALID (50%), scoreboarded bit stream:
  - No lost or duplicate bits.
  - FILL stays ≤ 66.
  - VALID is 0 only when fill_sum < 64.
- Hold DATA_IN constant while READY=0:
  - The stalled block is accepted exactly once on the next READY=1 edge.
- Assert SYSTEM_RESET_N low at FILL=35 mid-stream:
  - Outputs clear immediately (asynchronous).
  - After release, the first output word contains only the first post-reset block's top 64 bits.
- All-ones blocks interleaved with all-zero blocks:
  - Output words match the expected shifted pattern at every FILL value 0..66.

Source files
------------

// File: rtl/gearbox_67b_64b_pkg.sv
// Shared Interlaken block/SERDES widths and field positions, plus the
// helper that places a 67-bit block into the gearbox shift buffer.
package gearbox_67b_64b_pkg;

    localparam int INTERLAKEN_BLOCK_W = 67;
    localparam int SERDES_W           = 64;

    localparam int INV_BIT = 66;
    localparam int SYNC_HI = 65;
    localparam int SYNC_LO = 64;

    // One word of residue can never exceed a block, so block + word bounds the buffer
    localparam int BUF_W  = INTERLAKEN_BLOCK_W + SERDES_W;
    localparam int FILL_W = 7;

    typedef logic [INTERLAKEN_BLOCK_W-1:0] block_t;
    typedef logic [SERDES_W-1:0]           word_t;
    typedef logic [BUF_W-1:0]              buf_t;
    typedef logic [FILL_W-1:0]             fill_t;
    typedef logic [FILL_W:0]               fill_sum_t;

    // Left-align the block, then slide it down past the bits already held
    function automatic buf_t align_block(input block_t blk, input fill_t fill);
        buf_t aligned;
        aligned = {blk, {SERDES_W{1'b0}}};
        return aligned >> fill;
    endfunction

endpackage

// File: rtl/gearbox_67b_64b.sv
// 67b -> 64b transmit gearbox: appends encoder blocks to an MSB-first
// shift buffer and emits 64-bit words whenever at least 64 bits are held.
module gearbox_67b_64b
    import gearbox_67b_64b_pkg::*;
(
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [66:0] DATA_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    output logic [63:0] DATA_OUT,
    output logic        DATA_OUT_VALID
);

    buf_t      shift_reg, shift_next;
    fill_t     fill_reg, fill_next;
    word_t     data_out_reg, data_out_next;
    logic      valid_reg, valid_next;
    logic      ready_reg, ready_next;

    logic      accept;
    fill_sum_t fill_sum;
    buf_t      merged;

    assign accept = DATA_IN_VALID && ready_reg;

    // Bits below FILL are always zero, so the insert is a plain OR
    always_comb begin
        merged   = shift_reg;
        fill_sum = {1'b0, fill_reg};
        if (accept) begin
            merged   = shift_reg | align_block(DATA_IN, fill_reg);
            fill_sum = {1'b0, fill_reg} + fill_sum_t'(INTERLAKEN_BLOCK_W);
        end
    end

    always_comb begin
        shift_next    = merged;
        fill_next     = fill_t'(fill_sum);
        data_out_next = data_out_reg;
        valid_next    = 1'b0;
        if (fill_sum >= fill_sum_t'(SERDES_W)) begin
            data_out_next = merged[BUF_W-1 -: SERDES_W];
            shift_next    = merged << SERDES_W;
            fill_next     = fill_t'(fill_sum - fill_sum_t'(SERDES_W));
            valid_next    = 1'b1;
        end
        // A residue of 64..66 bits must drain before another block fits
        ready_next = (fill_next < fill_t'(SERDES_W));
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            shift_reg    <= '0;
            fill_reg     <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            fill_reg     <= fill_next;
            data_out_reg <= data_out_next;
            valid_reg    <= valid_next;
            ready_reg    <= ready_next;
        end
    end

    assign DATA_IN_READY  = ready_reg;
    assign DATA_OUT       = data_out_reg;
    assign DATA_OUT_VALID = valid_reg;

endmodule

// File: tb/tb_gearbox_67b_64b.sv
// Bench for gearbox_67b_64b: a bit-queue reference model of the serial
// stream checks every cycle, plus directed boundary checks.
module tb_gearbox_67b_64b;

    logic        USER_CLK;
    logic        SYSTEM_RESET_N;
    logic [66:0] DATA_IN;
    logic        DATA_IN_VALID;
    logic        DATA_IN_READY;
    logic [63:0] DATA_OUT;
    logic        DATA_OUT_VALID;

    gearbox_67b_64b dut (
        .USER_CLK       (USER_CLK),
        .SYSTEM_RESET_N (SYSTEM_RESET_N),
        .DATA_IN        (DATA_IN),
        .DATA_IN_VALID  (DATA_IN_VALID),
        .DATA_IN_READY  (DATA_IN_READY),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID)
    );

    initial USER_CLK = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    int tests  = 0;
    int failed = 0;

    // Reference model: pending serial bits, oldest first
    bit          q[$];
    logic        m_ready;
    logic [63:0] exp_out;
    logic        exp_valid;
    logic        last_acc;
    logic        obs_acc;
    logic [66:0] fill_seen;

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ready   = 1'b0;
        exp_out   = '0;
        exp_valid = 1'b0;
    endtask

    // One clock: drive, clock, update model, compare
    task automatic step(input logic v, input logic [66:0] d);
        logic acc;
        acc     = v && m_ready;
        obs_acc = v && DATA_IN_READY;
        if (q.size() <= 66) fill_seen[q.size()] = 1'b1;
        DATA_IN_VALID = v;
        DATA_IN       = d;
        @(posedge USER_CLK);
        #1;
        if (acc) for (int i = 66; i >= 0; i--) q.push_back(d[i]);
        if (q.size() >= 64) begin
            for (int i = 63; i >= 0; i--) exp_out[i] = q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        m_ready  = (q.size() < 64);
        last_acc = acc;
        chk("out_valid", {66'd0, DATA_OUT_VALID}, {66'd0, exp_valid});
        chk("out_data", {3'd0, DATA_OUT}, {3'd0, exp_out});
        chk("in_ready", {66'd0, DATA_IN_READY}, {66'd0, m_ready});
        chk("fill", {60'd0, dut.fill_reg}, 67'(q.size()));
    endtask

    task automatic do_reset();
        SYSTEM_RESET_N = 1'b0;
        DATA_IN_VALID  = 1'b0;
        #1;
        chk("rst_out", {3'd0, DATA_OUT}, 67'd0);
        chk("rst_valid", {66'd0, DATA_OUT_VALID}, 67'd0);
        chk("rst_ready", {66'd0, DATA_IN_READY}, 67'd0);
        chk("rst_fill", {60'd0, dut.fill_reg}, 67'd0);
        model_clear();
        repeat (2) @(posedge USER_CLK);
        #1;
        SYSTEM_RESET_N = 1'b1;
    endtask

    function automatic logic [66:0] rand_block();
        return {$urandom_range(0, 7), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [66:0] cur;
        logic [66:0] all_ones;
        int          first_low;
        int          nacc;
        int          nwords;
        int          n;

        SYSTEM_RESET_N = 1'b0;
        DATA_IN        = '0;
        DATA_IN_VALID  = 1'b0;
        fill_seen      = '0;
        model_clear();

        // Single block, then idle
        do_reset();
        step(1'b0, '0);
        chk("ready_after_release", {66'd0, DATA_IN_READY}, 67'd1);
        step(1'b1, {3'b010, 64'h0123456789ABCDEF});
        chk("single_word", {3'd0, DATA_OUT}, {3'd0, 64'h402468ACF13579BD});
        step(1'b0, '0);
        chk("single_residual", {64'd0, dut.shift_reg[130:128]}, 67'b111);
        repeat (3) step(1'b0, '0);

        // Continuous valid, header 01, incrementing payloads
        do_reset();
        n = 0; first_low = 0; nacc = 0; nwords = 0;
        cur = {1'b0, 2'b01, 64'(n)};
        for (int i = 1; i <= 150; i++) begin
            step(1'b1, cur);
            if (last_acc) begin n++; cur = {1'b0, 2'b01, 64'(n)}; end
            if (!DATA_IN_READY && first_low == 0) first_low = i;
            if (i >= 2 && i <= 68) begin
                if (obs_acc) nacc++;
                if (DATA_OUT_VALID) nwords++;
            end
        end
        chk("first_stall_cycle", 67'(first_low), 67'd23);
        chk("accepts_per_period", 67'(nacc), 67'd64);
        chk("words_per_period", 67'(nwords), 67'd67);

        // Random valid with held stalled blocks
        cur = rand_block();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), cur);
            if (last_acc) cur = rand_block();
        end

        // Mid-stream asynchronous reset at FILL=35
        do_reset();
        step(1'b0, '0);
        cur = rand_block();
        for (int i = 0; i < 300 && q.size() != 35; i++) begin
            step(1'b1, cur);
            if (last_acc) cur = rand_block();
        end
        chk("pre_rst_fill", {60'd0, dut.fill_reg}, 67'd35);
        #2;
        do_reset();
        step(1'b0, '0);
        cur = rand_block();
        step(1'b1, cur);
        chk("post_rst_word", {3'd0, DATA_OUT}, {3'd0, cur[66:3]});
        step(1'b0, '0);

        // Alternating all-ones / all-zeros across every FILL value
        do_reset();
        step(1'b0, '0);
        fill_seen = '0;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            cur = (n % 2 == 0) ? '1 : '0;
            step(1'b1, cur);
            if (last_acc) n++;
        end
        all_ones = '1;
        chk("fill_coverage", fill_seen, all_ones);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
